// File: rtl/mul_i16_arb.sv
// Round-robin front end sharing one mul_i16 among N_REQ requesters.
// Results come back in issue order through a credit-protected response FIFO.

module mul_i16 #(
  parameter bit FLOP_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        data_vld_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        signed_i,
  output logic        data_vld_o,
  output logic [31:0] c_o
);
  logic signed [16:0] a_ext, b_ext;
  logic signed [33:0] prod;

  // A 17-bit sign/zero extension lets one signed multiplier serve both modes.
  always_comb begin
    a_ext = {signed_i & a_i[15], a_i};
    b_ext = {signed_i & b_i[15], b_i};
    prod  = a_ext * b_ext;
  end

  if (FLOP_EN) begin : g_flop
    logic        vld_q, vld_d;
    logic [31:0] c_q, c_d;

    always_comb begin
      vld_d = data_vld_i;
      c_d   = data_vld_i ? prod[31:0] : c_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) vld_q <= 1'b0;
      else          vld_q <= vld_d;
    end

    always_ff @(posedge clk_i) c_q <= c_d;

    assign data_vld_o = vld_q;
    assign c_o        = c_q;
  end else begin : g_comb
    assign data_vld_o = data_vld_i;
    assign c_o        = prod[31:0];
  end
endmodule

module mul_i16_arb #(
  parameter int N_REQ      = 4,
  parameter bit FLOP_EN    = 1'b1,
  parameter int RESP_DEPTH = 2,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [N_REQ-1:0]    req_vld_i,
  output logic [N_REQ-1:0]    req_rdy_o,
  input  logic [N_REQ*16-1:0] req_a_i,
  input  logic [N_REQ*16-1:0] req_b_i,
  input  logic [N_REQ-1:0]    req_signed_i,
  output logic                rsp_vld_o,
  input  logic                rsp_rdy_i,
  output logic [ID_W-1:0]     rsp_id_o,
  output logic [31:0]         rsp_c_o,
  output logic                busy_o
);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 2);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     c;
  } rsp_t;

  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, grant;
  logic [ID_W:0]   idx, ptr_nxt;
  logic [CW-1:0]   cnt_q, cnt_d, occ_q, occ_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic            busy_q, busy_d;
  logic            found, can_issue, issue, pop, push;
  logic [15:0]     a_sel, b_sel;
  logic            s_sel;
  logic            mul_vld;
  logic [31:0]     mul_c;
  rsp_t            push_entry, head;
  rsp_t            mem_q [RESP_DEPTH];

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rsp_vld_o = (occ_q != '0);
  assign pop       = rsp_vld_o && rsp_rdy_i;
  assign can_issue = (cnt_q < CW'(RESP_DEPTH)) || pop;

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!found && req_vld_i[idx[ID_W-1:0]]) begin
        found = 1'b1;
        grant = idx[ID_W-1:0];
      end
    end
    issue = found && can_issue && rst_n_i;

    a_sel     = '0;
    b_sel     = '0;
    s_sel     = 1'b0;
    req_rdy_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        a_sel = req_a_i[16*i +: 16];
        b_sel = req_b_i[16*i +: 16];
        s_sel = req_signed_i[i];
      end
      req_rdy_o[i] = issue && (grant == ID_W'(i));
    end
  end

  mul_i16 #(.FLOP_EN(FLOP_EN)) u_mul (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .data_vld_i (issue),
    .a_i        (a_sel),
    .b_i        (b_sel),
    .signed_i   (s_sel),
    .data_vld_o (mul_vld),
    .c_o        (mul_c)
  );

  // The tag rides alongside the multiplier so it meets its product at push time.
  always_comb begin
    ptr_nxt    = {1'b0, grant} + 1'b1;
    ptr_d      = ptr_q;
    if (issue) ptr_d = (ptr_nxt == (ID_W+1)'(N_REQ)) ? '0 : ptr_nxt[ID_W-1:0];
    id_d       = issue ? grant : id_q;
    push       = mul_vld;
    push_entry = '{id: (FLOP_EN ? id_q : grant), c: mul_c};
    cnt_d      = cnt_q + CW'(issue) - CW'(pop);
    occ_d      = occ_q + CW'(push) - CW'(pop);
    wr_d       = push ? inc_ptr(wr_q) : wr_q;
    rd_d       = pop  ? inc_ptr(rd_q) : rd_q;
    busy_d     = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q  <= '0;
      id_q   <= '0;
      cnt_q  <= '0;
      occ_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      id_q   <= id_d;
      cnt_q  <= cnt_d;
      occ_q  <= occ_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      busy_q <= busy_d;
    end
  end

  // NOTE: FIFO storage is not reset; the registered empty flag gates what leaves it.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= push_entry;
  end

  assign head     = mem_q[rd_q];
  assign rsp_id_o = rsp_vld_o ? head.id : '0;
  assign rsp_c_o  = rsp_vld_o ? head.c  : '0;
  assign busy_o   = busy_q;
endmodule
